router_reg: RTL and testbench

- Datapath register stage driven by router_fsm's state decodes; sits between the packet source and the three output FIFOs.
- Latches the header, forwards header/payload/parity bytes to the FIFO write bus, holds one byte across a FIFO-full stall, accumulates XOR parity and reports a parity error.
- Returns parity_done and low_packet_valid to router_fsm.

---
 rtl/router_pkg.sv | 37 +++
 rtl/router_reg_if.sv | 43 ++++
 rtl/router_parity_acc.sv | 50 +++++
 rtl/router_reg.sv | 114 +++++++++++
 tb/tb_router_reg.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : router_pkg
//  Description : Shared constants, header slicing helpers and the router
//                control-FSM state encoding (shared with router_fsm).
//  Revision    : 1.0  initial release
// ============================================================================
package router_pkg;

    // Packet byte width and header field positions.
    localparam int DATA_W   = 8;
    localparam int ADDR_LSB = 0;
    localparam int ADDR_MSB = 1;
    localparam int LEN_LSB  = 2;

    // Control FSM states; router_reg sees these only as one-hot decodes.
    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        WAIT_TILL_EMPTY    = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } router_state_e;

    // Builds a header byte from destination address and payload length.
    function automatic logic [DATA_W-1:0] make_header(
        input logic [ADDR_MSB:ADDR_LSB]  addr,
        input logic [DATA_W-1:LEN_LSB]   len
    );
        return {len, addr};
    endfunction

endpackage : router_pkg
`default_nettype wire

// File: rtl/router_reg_if.sv
`default_nettype none
// ============================================================================
//  Module      : router_reg_if
//  Description : Bundle between the packet source / router_fsm decodes and
//                the router_reg datapath stage.
//                slave  : router_reg side (decodes and source in, results out)
//                master : driver side (source, FSM, FIFO full)
//  Ports       : pkt_valid, data_in, fifo_full, detect_add, lfd_state,
//                ld_state, laf_state, full_state, rst_int_reg  (to router_reg)
//                dout, parity_done, low_packet_valid, err       (from router_reg)
//  Revision    : 1.0  initial release
// ============================================================================
interface router_reg_if #(
    parameter int DATA_W = router_pkg::DATA_W
);
    logic              pkt_valid;
    logic [DATA_W-1:0] data_in;
    logic              fifo_full;
    logic              detect_add;
    logic              lfd_state;
    logic              ld_state;
    logic              laf_state;
    logic              full_state;
    logic              rst_int_reg;
    logic [DATA_W-1:0] dout;
    logic              parity_done;
    logic              low_packet_valid;
    logic              err;

    modport master (
        output pkt_valid, data_in, fifo_full,
        output detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
        input  dout, parity_done, low_packet_valid, err
    );

    modport slave (
        input  pkt_valid, data_in, fifo_full,
        input  detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
        output dout, parity_done, low_packet_valid, err
    );

endinterface : router_reg_if
`default_nettype wire

// File: rtl/router_parity_acc.sv
`default_nettype none
// ============================================================================
//  Module      : router_parity_acc
//  Description : Running XOR parity over header+payload, captured packet
//                parity byte, and their comparison.
//  Ports       : clock, reset      - clock / synchronous active-high reset
//                load              - seed running parity with data_in (header)
//                xor_en            - fold data_in into running parity (payload)
//                cap_en            - capture data_in as the packet parity byte
//                data_in           - source byte
//                mismatch          - running parity differs from captured byte
//  Revision    : 1.0  initial release
// ============================================================================
module router_parity_acc
    import router_pkg::*;
#(
    parameter int DATA_W = router_pkg::DATA_W
) (
    input  wire logic              clock,
    input  wire logic              reset,
    input  wire logic              load,
    input  wire logic              xor_en,
    input  wire logic              cap_en,
    input  wire logic [DATA_W-1:0] data_in,
    output logic                   mismatch
);

    logic [DATA_W-1:0] r_int_parity;
    logic [DATA_W-1:0] r_pkt_parity;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_int_parity <= '0;
            r_pkt_parity <= '0;
        end else begin
            if (load) begin
                r_int_parity <= data_in;
            end else if (xor_en) begin
                r_int_parity <= r_int_parity ^ data_in;
            end
            if (cap_en) begin
                r_pkt_parity <= data_in;
            end
        end
    end

    assign mismatch = (r_int_parity != r_pkt_parity);

endmodule : router_parity_acc
`default_nettype wire

// File: rtl/router_reg.sv
`default_nettype none
// ============================================================================
//  Module      : router_reg
//  Description : Router datapath register stage. Latches the header, drives
//                header/payload/parity bytes onto the FIFO write bus, parks one
//                byte across a FIFO-full stall, accumulates parity and flags a
//                parity error back to router_fsm.
//  Ports       : clock, reset  - clock / synchronous active-high reset
//                bus (slave)   - source byte, FSM state decodes, fifo_full in;
//                                dout, parity_done, low_packet_valid, err out
//  Revision    : 1.0  initial release
// ============================================================================
module router_reg
    import router_pkg::*;
#(
    parameter int DATA_W = router_pkg::DATA_W
) (
    input  wire logic     clock,
    input  wire logic     reset,
    router_reg_if.slave   bus
);

    logic [DATA_W-1:0] r_header_byte;
    logic [DATA_W-1:0] r_hold_byte;
    logic [DATA_W-1:0] r_dout;
    logic              r_parity_done;
    logic              r_low_packet_valid;
    logic              r_err;

    logic w_hdr_latch;
    logic w_payload;
    logic w_parity_byte;
    logic w_parity_done_set;
    logic w_mismatch;

    assign w_hdr_latch   = bus.detect_add && bus.pkt_valid;
    assign w_payload     = bus.ld_state && bus.pkt_valid;
    // pkt_valid drops on the parity byte, so a LOAD_DATA cycle without it
    // carries the packet parity.
    assign w_parity_byte = bus.ld_state && !bus.pkt_valid;

    // Parity is done either when the parity byte goes straight to the FIFO,
    // or when a stalled parity byte is replayed from hold_byte in LAF.
    assign w_parity_done_set = (w_parity_byte && !bus.fifo_full) ||
                               (bus.laf_state && r_low_packet_valid && !r_parity_done);

    router_parity_acc #(
        .DATA_W (DATA_W)
    ) u_parity_acc (
        .clock    (clock),
        .reset    (reset),
        .load     (w_hdr_latch),
        .xor_en   (w_payload),
        .cap_en   (w_parity_byte),
        .data_in  (bus.data_in),
        .mismatch (w_mismatch)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_header_byte      <= '0;
            r_hold_byte        <= '0;
            r_dout             <= '0;
            r_parity_done      <= 1'b0;
            r_low_packet_valid <= 1'b0;
            r_err              <= 1'b0;
        end else begin
            if (w_hdr_latch) begin
                r_header_byte <= bus.data_in;
            end

            // FIFO write data; untouched while stalled so the FIFO sees a
            // stable byte until the stall clears.
            if (bus.lfd_state) begin
                r_dout <= r_header_byte;
            end else if (bus.ld_state && !bus.fifo_full) begin
                r_dout <= bus.data_in;
            end else if (bus.laf_state) begin
                r_dout <= r_hold_byte;
            end

            if (bus.ld_state && bus.fifo_full) begin
                r_hold_byte <= bus.data_in;
            end

            if (w_hdr_latch) begin
                r_parity_done <= 1'b0;
            end else if (w_parity_done_set) begin
                r_parity_done <= 1'b1;
            end

            if (bus.rst_int_reg) begin
                r_low_packet_valid <= 1'b0;
            end else if (w_parity_byte) begin
                r_low_packet_valid <= 1'b1;
            end

            // err persists into the next DECODE_ADDRESS so router_fsm and
            // software can observe it; the next header clears it.
            if (w_hdr_latch) begin
                r_err <= 1'b0;
            end else if (bus.rst_int_reg) begin
                r_err <= w_mismatch;
            end
        end
    end

    assign bus.dout             = r_dout;
    assign bus.parity_done      = r_parity_done;
    assign bus.low_packet_valid = r_low_packet_valid;
    assign bus.err              = r_err;

endmodule : router_reg
`default_nettype wire

// File: tb/tb_router_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_router_reg
//  Description : Self-checking bench for router_reg. The bench plays the part
//                of router_fsm and the packet source, and predicts outputs
//                from packet-level rules (byte order, XOR of the packet).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_router_reg;
    import router_pkg::*;

    logic clock = 1'b0;
    logic reset;

    router_reg_if bus ();

    router_reg dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    // Expected outputs
    logic [7:0] exp_dout;
    logic       exp_pd;
    logic       exp_lpv;
    logic       exp_err;

    // Payload of the packet being sent
    logic [7:0] pl_q [$];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".dout"},             bus.dout,                   exp_dout);
        check({tag, ".parity_done"},      {7'd0, bus.parity_done},    {7'd0, exp_pd});
        check({tag, ".low_packet_valid"}, {7'd0, bus.low_packet_valid}, {7'd0, exp_lpv});
        check({tag, ".err"},              {7'd0, bus.err},            {7'd0, exp_err});
    endtask

    // Drive one cycle as router_fsm in state st, then sample 1 time unit
    // after the active edge.
    task automatic drive(input router_state_e st, input logic pv, input logic [7:0] d,
                         input logic ff);
        bus.detect_add  = (st == DECODE_ADDRESS);
        bus.lfd_state   = (st == LOAD_FIRST_DATA);
        bus.ld_state    = (st == LOAD_DATA);
        bus.laf_state   = (st == LOAD_AFTER_FULL);
        bus.full_state  = (st == FIFO_FULL_STATE);
        bus.rst_int_reg = (st == CHECK_PARITY_ERROR);
        bus.pkt_valid   = pv;
        bus.data_in     = d;
        bus.fifo_full   = ff;
        assert ($onehot0({bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state,
                          bus.full_state, bus.rst_int_reg}))
        else $fatal(1, "FAIL state_decodes overlap");
        @(posedge clock);
        #1;
    endtask

    task automatic clear_model();
        exp_dout = 8'h00;
        exp_pd   = 1'b0;
        exp_lpv  = 1'b0;
        exp_err  = 1'b0;
    endtask

    // Sends header, pl_q payload and parity byte par.
    //   stall_idx : byte index that meets fifo_full (len = parity byte, -1 none)
    //   stall_n   : number of FIFO_FULL_STATE cycles for that stall
    //   rst_after : reset after this many payload bytes (-1 none)
    //   idle_n    : DECODE_ADDRESS cycles without pkt_valid after the packet
    task automatic run_packet(input logic [7:0] hdr, input logic [7:0] par,
                              input int stall_idx, input int stall_n,
                              input int rst_after, input int idle_n);
        logic [7:0] x;
        logic       bad;
        int         len;
        len = pl_q.size();
        x   = hdr;
        foreach (pl_q[k]) x ^= pl_q[k];
        bad = (x != par);

        drive(DECODE_ADDRESS, 1'b1, hdr, 1'b0);
        exp_pd  = 1'b0;
        exp_err = 1'b0;
        check_all("hdr");

        drive(LOAD_FIRST_DATA, 1'b1, pl_q[0], 1'b0);
        exp_dout = hdr;
        check_all("lfd");

        for (int i = 0; i <= len; i++) begin
            logic [7:0] b;
            logic       pv;
            logic       full;
            pv   = (i < len);
            b    = pv ? pl_q[i] : par;
            full = (i == stall_idx);

            drive(LOAD_DATA, pv, b, full);
            if (!pv) exp_lpv = 1'b1;
            if (!full) begin
                exp_dout = b;
                if (!pv) exp_pd = 1'b1;
            end
            check_all(pv ? "ld_payload" : "ld_parity");

            if (full) begin
                repeat (stall_n) begin
                    drive(FIFO_FULL_STATE, pv, b, 1'b1);
                    check_all("stall");
                end
                drive(LOAD_AFTER_FULL, pv, b, 1'b0);
                exp_dout = b;
                if (!pv) exp_pd = 1'b1;
                check_all("laf");
            end

            if (i + 1 == rst_after) begin
                reset = 1'b1;
                drive(LOAD_DATA, 1'b1, 8'hC3, 1'b0);
                reset = 1'b0;
                clear_model();
                check_all("mid_reset");
                return;
            end
        end

        drive(LOAD_PARITY, 1'b0, par, 1'b0);
        check_all("load_parity");

        drive(CHECK_PARITY_ERROR, 1'b0, par, 1'b0);
        exp_lpv = 1'b0;
        exp_err = bad;
        check_all("check_parity");

        repeat (idle_n) begin
            drive(DECODE_ADDRESS, 1'b0, 8'h00, 1'b0);
            check_all("idle");
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        clear_model();
        reset = 1'b1;

        // Reset wins over a concurrent payload write.
        drive(LOAD_DATA, 1'b1, 8'h5A, 1'b0);
        check_all("reset");
        drive(DECODE_ADDRESS, 1'b1, 8'hA5, 1'b0);
        check_all("reset_hdr");
        reset = 1'b0;
        // No header was latched under reset, so header_byte is still 0.
        drive(LOAD_FIRST_DATA, 1'b1, 8'h77, 1'b0);
        check_all("post_reset_lfd");

        // Clean packet
        pl_q = '{8'h11, 8'h22, 8'h33};
        run_packet(8'h0D, 8'h0D, -1, 0, -1, 1);

        // Bad parity; err held through idle decode cycles
        run_packet(8'h0D, 8'hFF, -1, 0, -1, 2);

        // Stall on the second payload byte for 3 cycles
        run_packet(8'h0D, 8'h0D, 1, 3, -1, 1);

        // Stall on the parity byte
        run_packet(8'h0D, 8'h0D, 3, 2, -1, 1);

        // Reset after the second payload byte, then a clean packet
        run_packet(8'h0D, 8'h0D, -1, 0, 2, 0);
        run_packet(8'h0D, 8'h0D, -1, 0, -1, 1);

        // Back-to-back: bad then good
        run_packet(8'h0D, 8'hFF, -1, 0, -1, 0);
        run_packet(8'h0D, 8'h0D, -1, 0, -1, 2);

        // Randomized packets
        for (int n = 0; n < 25; n++) begin
            int         len;
            int         stall_idx;
            logic [7:0] hdr;
            logic [7:0] x;
            logic [7:0] par;
            len = $urandom_range(1, 6);
            hdr = make_header(2'($urandom_range(0, 2)), 6'(len));
            pl_q.delete();
            x = hdr;
            for (int k = 0; k < len; k++) begin
                pl_q.push_back(8'($urandom));
                x ^= pl_q[k];
            end
            par = ($urandom_range(0, 1) == 1) ? x : (x ^ 8'($urandom_range(1, 255)));
            stall_idx = $urandom_range(0, len + 1);
            if (stall_idx > len) stall_idx = -1;
            run_packet(hdr, par, stall_idx, $urandom_range(1, 4), -1, $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_router_reg
`default_nettype wire
